// File: rtl/frame_pkg.sv
// Shared constants and types for the frame readout path.
package frame_pkg;
  localparam int DEF_FRAME_W = 320;
  localparam int DEF_FRAME_H = 240;
  localparam int DEF_DATA_W  = 32;
  localparam int COL_W       = 9;
  localparam int ROW_W       = 8;
  // Sideband bits carried with each pixel: {last, eol, sof}
  localparam int TAG_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;
endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry fall-through FIFO: an arriving word is presented the same cycle
// when the FIFO is empty, and is captured only if the sink does not take it.
module pixel_skid_fifo #(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count_next
);
  logic [WIDTH-1:0] mem [2];
  logic             head_reg, tail_reg;
  logic [1:0]       count_reg;
  logic             empty, push, pop;

  assign empty     = (count_reg == 2'd0);
  assign pop       = !empty && out_ready;
  assign push      = in_valid && !(empty && out_ready);
  assign out_valid = !empty || in_valid;
  assign out_data  = !empty ? mem[head_reg] : (in_valid ? in_data : '0);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      if (push) tail_reg <= ~tail_reg;
      if (pop)  head_reg <= ~head_reg;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_reg] <= in_data;
  end
endmodule

// File: rtl/frame_reader.sv
// Raster-order frame readout from a 1-cycle-latency memory into a
// valid/ready pixel stream with start-of-frame and end-of-line marks.
module frame_reader
  import frame_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [COL_W-1:0]  rd_col,
  output logic [ROW_W-1:0]  rd_row,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              busy,
  output logic              done
);
  localparam int FIFO_W = DATA_W + TAG_W;

  state_t             state_reg, state_next;
  logic [COL_W-1:0]   col_reg, col_next, rd_col_reg;
  logic [ROW_W-1:0]   row_reg, row_next, rd_row_reg;
  logic               rd_en_reg, rd_q_reg, done_reg;
  logic [TAG_W-1:0]   tag_reg, rd_tag;
  logic               reading, issue, last_addr, credit_ok, accept, out_last;
  logic [1:0]         fifo_count_next;
  logic [FIFO_W-1:0]  fifo_out;

  assign last_addr = (col_reg == COL_W'(FRAME_W - 1)) && (row_reg == ROW_W'(FRAME_H - 1));
  // The read issued now lands after the one currently in flight, so both must fit.
  assign credit_ok = (fifo_count_next + {1'b0, rd_en_reg}) <= 2'd1;
  assign reading   = (state_reg == ST_RUN) || ((state_reg == ST_IDLE) && start);
  assign issue     = reading && credit_ok;
  assign accept    = out_valid && out_ready;

  assign rd_tag = {(rd_col_reg == COL_W'(FRAME_W - 1)) && (rd_row_reg == ROW_W'(FRAME_H - 1)),
                   (rd_col_reg == COL_W'(FRAME_W - 1)),
                   (rd_col_reg == '0) && (rd_row_reg == '0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = (issue && last_addr) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (issue && last_addr) state_next = ST_DRAIN;
      ST_DRAIN: if (accept && out_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg != ST_IDLE);
    col_next = col_reg;
    row_next = row_reg;
    if (issue) begin
      if (col_reg == COL_W'(FRAME_W - 1)) begin
        col_next = '0;
        row_next = (row_reg == ROW_W'(FRAME_H - 1)) ? '0 : row_reg + ROW_W'(1);
      end else begin
        col_next = col_reg + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg    <= '0;
      row_reg    <= '0;
      rd_en_reg  <= 1'b0;
      rd_col_reg <= '0;
      rd_row_reg <= '0;
      rd_q_reg   <= 1'b0;
      tag_reg    <= '0;
      done_reg   <= 1'b0;
    end else begin
      col_reg   <= col_next;
      row_reg   <= row_next;
      rd_en_reg <= issue;
      if (issue) begin
        rd_col_reg <= col_reg;
        rd_row_reg <= row_reg;
      end
      rd_q_reg <= rd_en_reg;
      tag_reg  <= rd_tag;
      done_reg <= (state_reg == ST_DRAIN) && accept && out_last;
    end
  end

  pixel_skid_fifo #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_q_reg),
    .in_data   ({tag_reg, rd_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out),
    .count_next(fifo_count_next)
  );

  assign {out_last, out_eol, out_sof, out_data} = fifo_out;
  assign rd_en  = rd_en_reg;
  assign rd_col = rd_col_reg;
  assign rd_row = rd_row_reg;
  assign done   = done_reg;
endmodule
